msm_bucket_accumulator: RTL and testbench

- Pippenger bucket stage directly upstream of the affine point adder: accepts (point, window digit) pairs and accumulates each point into bucket[digit].
- Sequences the external point adder through its Reset/Done handshake and resolves identity and inverse cases locally.
- Drains the finished buckets in descending index order to the bucket-reduction stage.
- Uses curve_point_t, P_WIDTH and inf_point from elliptic_curve_structs.

---
 rtl/elliptic_curve_structs.sv | 14 +
 rtl/msm_bucket_accumulator.sv | 235 +++++++++++++++++++++++
 tb/tb_msm_bucket_accumulator.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elliptic_curve_structs.sv
// Shared affine point representation for the MSM pipeline.
// The point at infinity is encoded as x = y = 0.
package elliptic_curve_structs;

  localparam int P_WIDTH = 256;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  localparam curve_point_t inf_point = '{x: {P_WIDTH{1'b0}}, y: {P_WIDTH{1'b0}}};

endpackage

// File: rtl/msm_bucket_accumulator.sv
// Pippenger bucket stage: folds (point, digit) pairs into bucket[digit] through an
// external affine adder, then streams the buckets out from the highest index down to 1.
module msm_bucket_accumulator
  import elliptic_curve_structs::*;
#(
  parameter int WINDOW   = 4,
  parameter int WATCHDOG = 4096
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  curve_point_t      in_point,
  input  logic [WINDOW-1:0] in_digit,
  input  logic              drain_start,
  output logic              out_valid,
  input  logic              out_ready,
  output curve_point_t      out_point,
  output logic [WINDOW-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              add_reset,
  output curve_point_t      add_P,
  output curve_point_t      add_Q,
  input  logic              add_done,
  input  curve_point_t      add_R,
  output logic              err_dbl,
  output logic              err_timeout
);

  localparam int NBUCKET = 2 ** WINDOW;
  localparam int CW      = $clog2(WATCHDOG + 1);
  localparam logic [WINDOW-1:0] MAX_IDX  = WINDOW'(NBUCKET - 1);
  localparam logic [WINDOW-1:0] ONE_IDX  = WINDOW'(1);
  localparam logic [WINDOW-1:0] ZERO_IDX = {WINDOW{1'b0}};
  localparam logic [CW-1:0]     WD_LIMIT = CW'(WATCHDOG);
  localparam logic [CW-1:0]     WD_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    LK_DISCARD = 3'd0,
    LK_FILL    = 3'd1,
    LK_DOUBLE  = 3'd2,
    LK_CANCEL  = 3'd3,
    LK_ADD     = 3'd4
  } lookup_t;

  function automatic logic same_x(input curve_point_t a, input curve_point_t b);
    return a.x == b.x;
  endfunction

  function automatic logic same_xy(input curve_point_t a, input curve_point_t b);
    return (a.x == b.x) && (a.y == b.y);
  endfunction

  state_t            state_r, state_s;
  lookup_t           lk_s;
  curve_point_t      bucket_r [NBUCKET];
  curve_point_t      bucket_s;
  curve_point_t      pt_r;
  curve_point_t      next_r;
  logic [WINDOW-1:0] digit_r;
  logic [CW-1:0]     wd_cnt_r;
  logic [CW-1:0]     wd_next_s;
  logic [WINDOW-1:0] prev_idx_s;

  assign in_ready   = (state_r == S_IDLE) && !drain_start;
  assign wd_next_s  = wd_cnt_r + WD_ONE;
  assign prev_idx_s = out_idx - ONE_IDX;

  // Classify the latched point against its bucket; identity and inverse cases never reach the adder.
  always_comb begin
    lk_s     = LK_ADD;
    bucket_s = bucket_r[digit_r];
    if (digit_r == ZERO_IDX || pt_r == inf_point) begin
      lk_s = LK_DISCARD;
    end else if (bucket_s == inf_point) begin
      lk_s = LK_FILL;
    end else if (same_xy(bucket_s, pt_r)) begin
      lk_s = LK_DOUBLE;
    end else if (same_x(bucket_s, pt_r)) begin
      lk_s = LK_CANCEL;
    end else begin
      lk_s = LK_ADD;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (drain_start) begin
          state_s = S_DRAIN;
        end else if (in_valid) begin
          state_s = S_LOOKUP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOOKUP: begin
        case (lk_s)
          LK_FILL, LK_CANCEL: state_s = S_WRITE;
          LK_ADD:             state_s = S_LAUNCH;
          default:            state_s = S_IDLE;
        endcase
      end
      S_LAUNCH: state_s = S_WAIT;
      S_WAIT: begin
        // A Done arriving on the final watchdog cycle still counts as a result.
        if (add_done) begin
          state_s = S_WRITE;
        end else if (wd_next_s == WD_LIMIT) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WRITE: state_s = S_IDLE;
      S_DRAIN: begin
        if (out_valid && out_ready && out_idx == ONE_IDX) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latching, adder sequencing, watchdog and sticky error flags.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pt_r        <= inf_point;
      digit_r     <= ZERO_IDX;
      next_r      <= inf_point;
      add_P       <= inf_point;
      add_Q       <= inf_point;
      wd_cnt_r    <= {CW{1'b0}};
      err_dbl     <= 1'b0;
      err_timeout <= 1'b0;
      add_reset   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      add_reset <= (state_s != S_WAIT);
      busy      <= (state_s != S_IDLE);
      if (in_valid && in_ready) begin
        pt_r    <= in_point;
        digit_r <= in_digit;
      end
      case (state_r)
        S_LOOKUP: begin
          case (lk_s)
            LK_FILL:   next_r  <= pt_r;
            LK_CANCEL: next_r  <= inf_point;
            LK_DOUBLE: err_dbl <= 1'b1;
            LK_ADD: begin
              add_P <= bucket_s;
              add_Q <= pt_r;
            end
            default: ;
          endcase
        end
        S_LAUNCH: wd_cnt_r <= {CW{1'b0}};
        S_WAIT: begin
          if (add_done) begin
            next_r <= add_R;
          end else begin
            wd_cnt_r <= wd_next_s;
            if (wd_next_s == WD_LIMIT) begin
              err_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bucket storage plus the registered drain stream; a bucket is cleared as it is handed off.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NBUCKET; i++) begin
        bucket_r[i] <= inf_point;
      end
      out_valid <= 1'b0;
      out_idx   <= ZERO_IDX;
      out_last  <= 1'b0;
      out_point <= inf_point;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (drain_start) begin
            out_valid <= 1'b1;
            out_idx   <= MAX_IDX;
            out_last  <= (MAX_IDX == ONE_IDX);
            out_point <= bucket_r[MAX_IDX];
          end
        end
        S_WRITE: bucket_r[digit_r] <= next_r;
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            bucket_r[out_idx] <= inf_point;
            if (out_idx == ONE_IDX) begin
              out_valid <= 1'b0;
            end else begin
              out_idx   <= prev_idx_s;
              out_last  <= (prev_idx_s == ONE_IDX);
              out_point <= bucket_r[prev_idx_s];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msm_bucket_accumulator.sv
// Randomised bench for msm_bucket_accumulator: a transaction-level bucket model predicts
// every cycle's handshake and drain outputs, and a few literal checks pin the model.
module tb_msm_bucket_accumulator;
  import elliptic_curve_structs::*;

  localparam int NB = 16;
  localparam int WD = 16;

  logic         clk = 1'b0;
  logic         Reset_n;
  logic         in_valid, in_ready, drain_start;
  curve_point_t in_point;
  logic [3:0]   in_digit;
  logic         out_valid, out_ready, out_last, busy, add_reset, add_done;
  curve_point_t out_point, add_P, add_Q, add_R;
  logic [3:0]   out_idx;
  logic         err_dbl, err_timeout;

  always #5 clk = ~clk;

  msm_bucket_accumulator #(.WINDOW(4), .WATCHDOG(WD)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_point(in_point), .in_digit(in_digit),
    .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .add_reset(add_reset), .add_P(add_P), .add_Q(add_Q),
    .add_done(add_done), .add_R(add_R),
    .err_dbl(err_dbl), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ar_low   = 0;

  // model state
  curve_point_t mb [NB];
  curve_point_t cap [NB];
  logic         m_err_dbl, m_err_to;
  curve_point_t m_P, m_Q;

  // per-cycle expectations
  logic         chk_en = 1'b0;
  logic         exp_in_ready, exp_busy, exp_add_reset, exp_out_valid, exp_out_last;
  curve_point_t exp_out_point;
  int           exp_out_idx;

  function automatic curve_point_t mk(input int unsigned x, input int unsigned y);
    curve_point_t p;
    p.x = P_WIDTH'(x);
    p.y = P_WIDTH'(y);
    return p;
  endfunction

  task automatic chk_b(input string n, input logic a, input logic e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_v(input string n, input int a, input int e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_p(input string n, input curve_point_t a, input curve_point_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual (%0h,%0h) required (%0h,%0h) at %0t", n, a.x, a.y, e.x, e.y, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NB; i++) mb[i] = inf_point;
    m_err_dbl = 1'b0;
    m_err_to  = 1'b0;
    m_P       = inf_point;
    m_Q       = inf_point;
  endtask

  task automatic set_idle();
    exp_in_ready  = 1'b1;
    exp_busy      = 1'b0;
    exp_add_reset = 1'b1;
    exp_out_valid = 1'b0;
  endtask

  task automatic set_busy(input logic ar);
    exp_in_ready  = 1'b0;
    exp_busy      = 1'b1;
    exp_add_reset = ar;
    exp_out_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_b("in_ready", in_ready, exp_in_ready);
      chk_b("busy", busy, exp_busy);
      chk_b("add_reset", add_reset, exp_add_reset);
      chk_b("out_valid", out_valid, exp_out_valid);
      chk_b("err_dbl", err_dbl, m_err_dbl);
      chk_b("err_timeout", err_timeout, m_err_to);
      chk_p("add_P", add_P, m_P);
      chk_p("add_Q", add_Q, m_Q);
      if (exp_out_valid) begin
        chk_p("out_point", out_point, exp_out_point);
        chk_v("out_idx", int'(out_idx), exp_out_idx);
        chk_b("out_last", out_last, exp_out_last);
      end
    end
  end

  always @(negedge clk) begin
    if (Reset_n && add_reset === 1'b0) ar_low++;
  end

  // One accumulate transaction; lat is the WAIT index at which the stub adder answers (<0: never).
  task automatic send(input curve_point_t p, input int d, input int lat, input curve_point_t r);
    curve_point_t b;
    int cls;
    drain_start = 1'b0;
    in_valid    = 1'b1;
    in_point    = p;
    in_digit    = 4'(d);
    add_done    = 1'($urandom_range(0, 1));
    add_R       = mk($urandom_range(0, 3), $urandom_range(0, 3));
    set_idle();
    cyc();
    b = mb[d];
    if (d == 0 || p == inf_point)                  cls = 0;
    else if (b == inf_point)                       cls = 1;
    else if (b.x == p.x && b.y == p.y)             cls = 2;
    else if (b.x == p.x)                           cls = 3;
    else                                           cls = 4;
    in_valid = 1'($urandom_range(0, 1));
    in_point = mk($urandom_range(0, 3), $urandom_range(0, 3));
    in_digit = 4'($urandom_range(0, 15));
    set_busy(1'b1);
    cyc();
    in_valid = 1'b0;
    case (cls)
      0: set_idle();
      2: begin
        m_err_dbl = 1'b1;
        set_idle();
      end
      1, 3: begin
        set_busy(1'b1);
        cyc();
        mb[d] = (cls == 1) ? p : inf_point;
        set_idle();
      end
      default: begin
        m_P = b;
        m_Q = p;
        set_busy(1'b1);
        add_done = 1'b1;
        cyc();
        for (int j = 0; j < WD; j++) begin
          set_busy(1'b0);
          add_done = (j == lat);
          add_R    = (j == lat) ? r : mk($urandom, $urandom);
          cyc();
          if (j == lat) begin
            set_busy(1'b1);
            add_done = 1'($urandom_range(0, 1));
            cyc();
            mb[d] = r;
            break;
          end
          if (j == WD - 1) m_err_to = 1'b1;
        end
        add_done = 1'($urandom_range(0, 1));
        set_idle();
      end
    endcase
  endtask

  // Drain all buckets; mode 0 = always ready, mode 1 = ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input logic with_input);
    int idx;
    int k;
    drain_start   = 1'b1;
    in_valid      = with_input;
    in_point      = mk(1, 1);
    in_digit      = 4'd5;
    out_ready     = 1'($urandom_range(0, 1));
    add_done      = 1'($urandom_range(0, 1));
    exp_in_ready  = 1'b0;
    exp_busy      = 1'b0;
    exp_add_reset = 1'b1;
    exp_out_valid = 1'b0;
    cyc();
    in_valid = 1'b0;
    idx = NB - 1;
    k = 0;
    while (idx >= 1 && k < 300) begin
      drain_start   = 1'($urandom_range(0, 1));
      add_done      = 1'($urandom_range(0, 1));
      exp_in_ready  = 1'b0;
      exp_busy      = 1'b1;
      exp_add_reset = 1'b1;
      exp_out_valid = 1'b1;
      exp_out_point = mb[idx];
      exp_out_idx   = idx;
      exp_out_last  = (idx == 1);
      out_ready     = (mode == 0) ? 1'b1 : (k % 3 == 0);
      cap[idx]      = out_point;
      cyc();
      if (out_ready) begin
        mb[idx] = inf_point;
        idx--;
      end
      k++;
    end
    chk_v("drain_completed", idx, 0);
    drain_start = 1'b0;
    out_ready   = 1'($urandom_range(0, 1));
    set_idle();
  endtask

  task automatic reset_mid_wait();
    drain_start = 1'b0;
    in_valid    = 1'b1;
    in_point    = mk(1, 2);
    in_digit    = 4'd2;
    add_done    = 1'b0;
    set_idle();
    cyc();
    in_valid = 1'b0;
    set_busy(1'b1);
    cyc();
    m_P = mb[2];
    m_Q = mk(1, 2);
    set_busy(1'b1);
    cyc();
    repeat (3) begin
      set_busy(1'b0);
      cyc();
    end
    chk_b("d6_in_wait", add_reset, 1'b0);
    chk_en  = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk_b("d6_add_reset", add_reset, 1'b1);
    chk_b("d6_busy", busy, 1'b0);
    chk_b("d6_in_ready", in_ready, 1'b1);
    chk_b("d6_out_valid", out_valid, 1'b0);
    chk_b("d6_err_dbl", err_dbl, 1'b0);
    chk_b("d6_err_timeout", err_timeout, 1'b0);
    chk_p("d6_add_P", add_P, inf_point);
    chk_p("d6_add_Q", add_Q, inf_point);
    m_reset();
    set_idle();
    chk_en = 1'b1;
    cyc();
    Reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    int d, lat;
    Reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_point    = inf_point;
    in_digit    = 4'd0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
    add_done    = 1'b0;
    add_R       = inf_point;
    m_reset();
    set_idle();
    chk_en = 1'b1;
    repeat (3) cyc();
    Reset_n = 1'b1;

    // first point into an empty bucket, then a full drain
    ar_low = 0;
    send(mk(5, 7), 3, 0, inf_point);
    chk_v("d1_add_reset_low", ar_low, 0);
    drain(0, 1'b0);
    chk_p("d1_bucket3", cap[3], mk(5, 7));
    chk_p("d1_bucket15", cap[15], inf_point);
    chk_p("d1_bucket1", cap[1], inf_point);

    // adder path: Done six cycles after add_reset falls -> seven low cycles in total
    send(mk(5, 7), 3, 0, inf_point);
    ar_low = 0;
    send(mk(9, 11), 3, 6, mk(100, 200));
    chk_v("d2_reset_low_cycles", ar_low, 7);
    chk_p("d2_add_P", add_P, mk(5, 7));
    chk_p("d2_add_Q", add_Q, mk(9, 11));

    // doubling, inverse, discards
    send(mk(5, 7), 7, 0, inf_point);
    send(mk(5, 7), 7, 0, inf_point);
    chk_b("d3_err_dbl", err_dbl, 1'b1);
    ar_low = 0;
    send(mk(5, 8), 7, 0, inf_point);
    chk_v("d3_no_launch", ar_low, 0);
    send(mk(4, 4), 0, 0, inf_point);
    send(inf_point, 5, 0, inf_point);

    // watchdog with a silent adder
    send(mk(1, 2), 9, 0, inf_point);
    send(mk(3, 4), 9, -1, inf_point);
    chk_b("d4_err_timeout", err_timeout, 1'b1);
    drain(0, 1'b0);
    chk_p("d2_bucket3", cap[3], mk(100, 200));
    chk_p("d3_bucket7", cap[7], inf_point);
    chk_p("d4_bucket9", cap[9], mk(1, 2));
    chk_p("d3_bucket5", cap[5], inf_point);

    // randomized traffic over a small coordinate range to provoke collisions
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        add_done = 1'($urandom_range(0, 1));
        set_idle();
        cyc();
      end
      d   = $urandom_range(0, 15);
      lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 10);
      send(mk($urandom_range(0, 3), $urandom_range(0, 3)), d, lat, mk($urandom, $urandom));
    end

    // drain under backpressure with a competing input, then confirm everything emptied
    drain(1, 1'b1);
    drain(0, 1'b0);
    chk_p("d5_input_rejected", cap[5], inf_point);

    // async reset in the middle of WAIT
    send(mk(3, 3), 2, 0, inf_point);
    reset_mid_wait();
    send(mk(6, 6), 4, 0, inf_point);
    drain(0, 1'b0);
    chk_p("d6_bucket2_lost", cap[2], inf_point);
    chk_p("d6_bucket4", cap[4], mk(6, 6));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
